game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the dinosaur runner. Owns the game state machine (idle, running, crashed) and drives the shared scroll datapath: the ground, cactus and cloud renderers all read `game_status`, `speed` and `scroll_pos` from this block. Advances once per video frame from `frame_tick`, keeps score and raises speed as the score grows.

## Interface

- `INIT_SPEED`, 1: speed loaded on every new game
- `MAX_SPEED`, 12: speed saturation value (≤ 15)
- `SCORE_DIV`, 6: frames per score point
- `SPEED_STEP`, 100: score points per speed increment
- `CRASH_HOLD`, 30: frames after a crash during which start is ignored
- `SCROLL_WRAP`, 640: scroll position modulus (≤ 1024)

- `clk` in 1: system clock
- `N_rst` in 1: asynchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse per video frame (vsync)
- `start_btn` in 1: debounced, clk-synchronous start/jump button level
- `collision` in 1: dino/obstacle overlap from the pixel mixer, level
- `game_status` out 1: 1 while RUN
- `crashed` out 1: 1 while CRASH
- `speed` out 4: pixels scrolled per frame
- `scroll_pos` out 10: ground scroll offset, 0..SCROLL_WRAP-1
- `score` out 14: binary score, saturates at 9999
- `new_game` out 1: one-cycle pulse on entry to RUN

## Operation

- States: IDLE, RUN, CRASH.
- IDLE → RUN on rising edge of `start_btn`. CRASH → RUN on rising edge of `start_btn` only once lockout counter reaches CRASH_HOLD. RUN → CRASH when `collision`=1 in any cycle.
- Entry to RUN: score=0, speed=INIT_SPEED, scroll_pos=0, frame divider=0, `new_game`=1 for one cycle.
- In RUN, on `frame_tick`: scroll_pos ← scroll_pos+speed; if result ≥ SCROLL_WRAP, subtract SCROLL_WRAP (11-bit intermediate). Frame divider increments; at SCORE_DIV-1 it clears and score increments (saturates at 9999).
- When score increments to a nonzero multiple of SPEED_STEP, speed increments, saturating at MAX_SPEED.
- In IDLE and CRASH: scroll_pos, score, speed frozen (score/speed remain visible after crash).
- Entry to CRASH clears lockout counter; it increments per `frame_tick`, saturating at CRASH_HOLD.
- Start edge while RUN ignored. Collision outside RUN ignored.
- Simultaneous `collision` and `frame_tick` in RUN: crash wins, no scroll or score update that cycle.
- Start edge held across lockout expiry does not restart; a fresh rising edge is required.

## Timing

- All outputs registered; state/outputs change on the clk edge after the cause (1-cycle latency).
- `game_status`/`crashed` decode registered state; `new_game` high in the first RUN cycle only.
- Reset values: state IDLE, `game_status`=0, `crashed`=0, `speed`=INIT_SPEED, `scroll_pos`=0, `score`=0, `new_game`=0, counters 0, edge-detect register 0.
- Reset mid-game returns to IDLE immediately (asynchronous), no `new_game` pulse.

## Structure

- Shared package `game_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, CRASH=2'd2), SCORE_MAX=9999, default parameter values, widths for speed/scroll/score so renderers agree.
- One sub-module `rise_detect` (registered previous level, one-cycle pulse on 0→1) for `start_btn`.
- Rest (FSM, frame divider, score, speed ramp, scroll accumulator, lockout counter) in `game_ctrl`.

## Test plan

- Reset, then start rising edge → `new_game` pulse next cycle, `game_status`=1, speed=1, scroll_pos=0; 10 frame ticks → scroll_pos=10, score=1.
- Run 600 frames (score reaches 100) → speed=2 on the frame score becomes 100; force score near 9999 → score holds 9999, speed holds 12.
- speed=7, scroll_pos=636, frame_tick → scroll_pos=3.
- collision and frame_tick same cycle at scroll_pos=50 → `crashed`=1, scroll_pos stays 50, score unchanged.
- In CRASH, start edge after 10 frames → stays CRASH; fresh edge after 30 frames → RUN, score=0, speed=1.
- Assert `N_rst` low mid-RUN → all outputs at reset values in same cycle; release, no activity until start edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the dino-runner game sequencer and its scroll renderers.
// Renderers import the widths below so that all of them agree on the bus format.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } game_state_t;

  localparam int SCORE_MAX = 9999;

  localparam int SPEED_W  = 4;
  localparam int SCROLL_W = 10;
  localparam int SCORE_W  = 14;

  localparam int DEF_INIT_SPEED  = 1;
  localparam int DEF_MAX_SPEED   = 12;
  localparam int DEF_SCORE_DIV   = 6;
  localparam int DEF_SPEED_STEP  = 100;
  localparam int DEF_CRASH_HOLD  = 30;
  localparam int DEF_SCROLL_WRAP = 640;

endpackage

// File: rtl/game_ctrl_if.sv
// Game controller bus: player/mixer inputs plus the shared scroll datapath outputs.
// master = the sequencer, slave = whoever drives the inputs and reads the status.
interface game_ctrl_if;
  import game_pkg::*;

  logic                frame_tick;
  logic                start_btn;
  logic                collision;
  logic                game_status;
  logic                crashed;
  logic [SPEED_W-1:0]  speed;
  logic [SCROLL_W-1:0] scroll_pos;
  logic [SCORE_W-1:0]  score;
  logic                new_game;

  modport master (
    input  frame_tick, start_btn, collision,
    output game_status, crashed, speed, scroll_pos, score, new_game
  );

  modport slave (
    output frame_tick, start_btn, collision,
    input  game_status, crashed, speed, scroll_pos, score, new_game
  );

endinterface

// File: rtl/game_ctrl_rise_detect.sv
// Rising-edge detector: registered previous level, one-cycle pulse on a 0->1 input.
// The pulse is combinational from the live level so the consumer reacts on the first high edge.
module rise_detect (
  input  logic clk,
  input  logic N_rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: idle/run/crash FSM, frame divider, score, speed ramp, scroll accumulator
// and post-crash start lockout. All outputs are registered (one clk of latency).
module game_ctrl
  import game_pkg::*;
#(
  parameter int INIT_SPEED  = DEF_INIT_SPEED,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int SCORE_DIV   = DEF_SCORE_DIV,
  parameter int SPEED_STEP  = DEF_SPEED_STEP,
  parameter int CRASH_HOLD  = DEF_CRASH_HOLD,
  parameter int SCROLL_WRAP = DEF_SCROLL_WRAP
) (
  input logic         clk,
  input logic         N_rst,
  game_ctrl_if.master io
);

  localparam int DIV_W  = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int LOCK_W = $clog2(CRASH_HOLD + 1);

  localparam logic [SPEED_W-1:0]  SPD_INIT  = SPEED_W'(INIT_SPEED);
  localparam logic [SPEED_W-1:0]  SPD_MAX   = SPEED_W'(MAX_SPEED);
  localparam logic [SCORE_W-1:0]  SCORE_TOP = SCORE_W'(SCORE_MAX);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [LOCK_W-1:0]   LOCK_FULL = LOCK_W'(CRASH_HOLD);
  localparam logic [SCROLL_W:0]   WRAP_X    = (SCROLL_W+1)'(SCROLL_WRAP);

  game_state_t         state;
  logic [DIV_W-1:0]    div_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [SPEED_W-1:0]  speed;
  logic [SCROLL_W-1:0] scroll_pos;
  logic [SCORE_W-1:0]  score;
  logic                new_game;

  logic                start_rise;
  logic                go;
  logic [SCROLL_W:0]   scroll_sum;
  logic [SCROLL_W-1:0] scroll_nxt;

  rise_detect u_start_edge (
    .clk   (clk),
    .N_rst (N_rst),
    .level (io.start_btn),
    .pulse (start_rise)
  );

  // One extra bit on the sum so a wrap past SCROLL_WRAP is never lost to overflow.
  always_comb begin
    scroll_sum = {1'b0, scroll_pos} + {{(SCROLL_W+1-SPEED_W){1'b0}}, speed};
    scroll_nxt = SCROLL_W'(scroll_sum);
    if (scroll_sum >= WRAP_X) scroll_nxt = SCROLL_W'(scroll_sum - WRAP_X);
  end

  assign go = start_rise && ((state == IDLE) || ((state == CRASH) && (lock_cnt == LOCK_FULL)));

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      step_cnt   <= '0;
      lock_cnt   <= '0;
      speed      <= SPD_INIT;
      scroll_pos <= '0;
      score      <= '0;
      new_game   <= 1'b0;
    end else begin
      new_game <= 1'b0;
      if (go) begin
        state      <= RUN;
        div_cnt    <= '0;
        step_cnt   <= '0;
        speed      <= SPD_INIT;
        scroll_pos <= '0;
        score      <= '0;
        new_game   <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            // Collision beats a same-cycle frame tick: the crash frame is not scored.
            if (io.collision) begin
              state    <= CRASH;
              lock_cnt <= '0;
            end else if (io.frame_tick) begin
              scroll_pos <= scroll_nxt;
              if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (score != SCORE_TOP) begin
                  score <= score + SCORE_W'(1);
                  if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (speed != SPD_MAX) speed <= speed + SPEED_W'(1);
                  end else begin
                    step_cnt <= step_cnt + STEP_W'(1);
                  end
                end
              end else begin
                div_cnt <= div_cnt + DIV_W'(1);
              end
            end
          end
          CRASH: begin
            if (io.frame_tick && (lock_cnt != LOCK_FULL)) lock_cnt <= lock_cnt + LOCK_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.game_status = (state == RUN);
  assign io.crashed     = (state == CRASH);
  assign io.speed       = speed;
  assign io.scroll_pos  = scroll_pos;
  assign io.score       = score;
  assign io.new_game    = new_game;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized and directed bench for game_ctrl against a frame-count based reference model.
module tb_game_ctrl;

  logic clk;
  logic N_rst;
  int   n_cmp;
  int   n_bad;

  game_ctrl_if io ();

  game_ctrl dut (
    .clk   (clk),
    .N_rst (N_rst),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [30:0] RESET_VEC = {1'b0, 1'b0, 4'd1, 10'd0, 14'd0, 1'b0};

  logic [30:0] dut_vec;
  assign dut_vec = {io.game_status, io.crashed, io.speed, io.scroll_pos, io.score, io.new_game};

  // Model: the score and speed follow from the number of frames seen in the current game.
  bit m_run, m_crash, m_newg, m_prev;
  int m_frames, m_scroll, m_lock;

  function automatic int m_score();
    int s;
    s = m_frames / 6;
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic int m_speed();
    int s;
    s = 1 + m_score() / 100;
    return (s > 12) ? 12 : s;
  endfunction

  function automatic logic [30:0] m_vec();
    return {m_run, m_crash, 4'(m_speed()), 10'(m_scroll), 14'(m_score()), m_newg};
  endfunction

  task automatic model_reset();
    m_run = 0; m_crash = 0; m_newg = 0; m_prev = 0;
    m_frames = 0; m_scroll = 0; m_lock = 0;
  endtask

  task automatic model_start();
    m_run = 1; m_crash = 0; m_frames = 0; m_scroll = 0; m_newg = 1;
  endtask

  task automatic model_step(input bit ft, input bit sb, input bit col);
    bit rise;
    rise   = sb && !m_prev;
    m_prev = sb;
    m_newg = 0;
    if (m_run) begin
      if (col) begin
        m_run = 0; m_crash = 1; m_lock = 0;
      end else if (ft) begin
        m_scroll = (m_scroll + m_speed()) % 640;
        m_frames++;
      end
    end else if (m_crash) begin
      if (rise && m_lock >= 30) model_start();
      else if (ft && m_lock < 30) m_lock++;
    end else if (rise) begin
      model_start();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, compare at the next negedge.
  task automatic tick(input bit ft, input bit sb, input bit col);
    io.frame_tick = ft;
    io.start_btn  = sb;
    io.collision  = col;
    @(posedge clk);
    model_step(ft, sb, col);
    @(negedge clk);
    chk("outs", {1'b0, dut_vec}, {1'b0, m_vec()});
  endtask

  logic [9:0]  held_scroll;
  logic [13:0] held_score;
  bit          rb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    N_rst = 1'b0;
    io.frame_tick = 1'b0;
    io.start_btn  = 1'b0;
    io.collision  = 1'b0;
    model_reset();

    @(negedge clk);
    chk("reset", {1'b0, dut_vec}, {1'b0, RESET_VEC});
    N_rst = 1'b1;

    repeat (3) tick(1, 0, 0);
    chk("idle_hold", {1'b0, dut_vec}, {1'b0, RESET_VEC});

    tick(0, 1, 0);
    chk("new_game", io.new_game, 1);
    chk("run_status", io.game_status, 1);
    chk("init_speed", io.speed, 1);
    chk("init_scroll", io.scroll_pos, 0);
    repeat (10) tick(1, 0, 0);
    chk("scroll10", io.scroll_pos, 10);
    chk("score1", io.score, 1);
    chk("new_game_low", io.new_game, 0);

    tick(1, 1, 0);
    chk("start_in_run", io.new_game, 0);
    while (m_frames < 599) tick(1, 0, 0);
    chk("speed_pre100", io.speed, 1);
    tick(1, 0, 0);
    chk("score100", io.score, 100);
    chk("speed100", io.speed, 2);

    while (m_frames < 60000) tick(1, 0, 0);
    chk("score_sat", io.score, 9999);
    chk("speed_sat", io.speed, 12);

    held_scroll = io.scroll_pos;
    held_score  = io.score;
    tick(1, 0, 1);
    chk("crash_flag", io.crashed, 1);
    chk("crash_scroll", io.scroll_pos, held_scroll);
    chk("crash_score", io.score, held_score);
    chk("crash_status", io.game_status, 0);

    repeat (10) tick(1, 0, 0);
    tick(0, 1, 0);
    chk("lockout_edge", io.crashed, 1);
    repeat (25) tick(1, 1, 1);
    chk("held_btn", io.crashed, 1);
    chk("crash_speed_kept", io.speed, 12);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("restart_status", io.game_status, 1);
    chk("restart_score", io.score, 0);
    chk("restart_speed", io.speed, 1);
    chk("restart_pulse", io.new_game, 1);

    repeat (5) tick(1, 0, 0);
    #2 N_rst = 1'b0;
    #1 chk("reset_async", {1'b0, dut_vec}, {1'b0, RESET_VEC});
    model_reset();
    @(negedge clk);
    N_rst = 1'b1;
    repeat (20) tick(1, 0, 1);
    chk("post_reset_idle", {1'b0, dut_vec}, {1'b0, RESET_VEC});

    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rb = ~rb;
      tick($urandom_range(2) == 0, rb, $urandom_range(59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
